turbo_block_encoder: RTL
========================

// Module: turbo_block_encoder
// PURPOSE
//  Rate-1/3 turbo encoder: the transmit-side partner of the max-log-MAP SISO decoder.
//  - Buffers K info bits, then emits K data steps plus 2 tail steps (sys, par1, par2).
//  - Uses the same 4-state trellis as the decoder: next state = {u, s[1]}, parity = u ^ s[0].
//  - Encoder 1 takes natural-order bits; encoder 2 takes interleaved bits.
//  - Feeds the channel-symbol mapper and decoder testbenches.
// PARAMETERS
//  K       19  info bits per block (K+2 = 21 trellis steps, matching decoder block_size)
//  P       7   interleaver stride, pi(k) = (P*k + OFF) mod K; gcd(P,K)=1, 0<P<K (not checked in RTL)
//  OFF     0   interleaver offset, 0 <= OFF < K
// PORTS
//  clk_p_i      in   1  clock, rising edge
//  rst_n_i      in   1  synchronous active-low reset
//  in_bit_i     in   1  info bit
//  in_valid_i   in   1  info bit valid
//  in_ready_o   out  1  high only in LOAD
//  sys_o        out  1  systematic bit of current step
//  par1_o       out  1  parity, encoder 1
//  par2_o       out  1  parity, encoder 2
//  par_en_o     out  2  [0]=par1 transmitted, [1]=par2 transmitted
//  out_valid_o  out  1  step data valid
//  out_ready_i  in   1  downstream accepts step
//  out_last_o   out  1  high on step K+1 (final tail step)
// BEHAVIOUR
//  - Reset (rst_n_i=0 at posedge):
//    - FSM=LOAD; wr_cnt=0, step=0, addr=OFF, both encoder states=0.
//    - in_ready_o=1; out_valid_o=0, out_last_o=0; sys_o/par1_o/par2_o=0.
//    - Bit buffer is not cleared.
//    - Reset mid-block aborts the block; no partial output follows.
//  - FSM LOAD -> ENCODE -> TAIL -> LOAD.
//  - LOAD
//    - in_valid_i & in_ready_o writes buf[wr_cnt] and increments wr_cnt.
//    - The K-th accepted bit moves to ENCODE on the next cycle.
//    - Latency: out_valid_o is high the cycle after the K-th acceptance.
//  - ENCODE, step k = 0..K-1, beat fires on out_valid_o & out_ready_i
//    - sys_o = buf[k]
//    - par1_o = buf[k] ^ s1[0]
//    - par2_o = buf[addr] ^ s2[0]
//    - On a fired beat:
//      - s1 <= {buf[k], s1[1]}
//      - s2 <= {buf[addr], s2[1]}
//      - step++
//      - addr <= (addr+P >= K) ? addr+P-K : addr+P   (no multiplier, no mod)
//    - Beat K-1 moves to TAIL.
//  - TAIL, steps K and K+1
//    - u=0 on both encoders; sys_o=0; par1_o=s1[0], par2_o=s2[0].
//    - Both encoders reach state 0 after 2 beats (feed-forward trellis).
//    - out_last_o=1 on step K+1; its beat returns to LOAD with step=0, addr=OFF, s1=s2=0.
//  - Backpressure
//    - While out_ready_i=0, all outputs hold stable; out_valid_o never drops mid-block.
//    - No combinational path from out_ready_i to any output.
//  - Input side
//    - in_valid_i outside LOAD is ignored; in_ready_o=0 outside LOAD.
//    - Next block loads only after the last tail beat; no overlap.
//  - Widths: wr_cnt, step and addr are $clog2(K+2) bits; all arithmetic is unsigned.
// CONFIGURATION
//  TURBO_ENC_PUNCT_EN
//  - Undefined: par_en_o = 2'b11 on every step (rate 1/3).
//  - Defined, ENCODE steps: par_en_o = 2'b01 on even k, 2'b10 on odd k (rate 1/2).
//  - Defined, TAIL steps: par_en_o = 2'b11.
//  - Data outputs are identical with or without the macro; only par_en_o changes.
// STRUCTURE
//  - Package turbo_pkg holds:
//    - FSM enum {LOAD, ENCODE, TAIL}
//    - TAIL_LEN=2, N_STATES=4
//    - functions trellis_next(s,u) and trellis_par(s,u), shared with the SISO decoder
//  - Sub-module rsc_enc_core, instantiated twice:
//    - ports: clk, rst_n, clr, step_en, u -> par, state
// TESTING
//  Bench config: K=19, P=7, OFF=0, out_ready_i=1 unless stated.
//  - All-zero block: 19 zero bits -> 21 beats, all outputs 0, out_last_o only on beat 20.
//  - Single 1 at index 1:
//    - sys=1 at k=1 only.
//    - par1=1 at k=1,3.
//    - par2=1 at k=11,13 (pi(11)=1).
//  - Backpressure: drop out_ready_i for 5 cycles at k=3 -> outputs/step frozen; sequence matches no-stall golden.
//  - Reset: assert rst_n_i for 1 cycle at k=8 -> in_ready_o=1 and out_valid_o=0 next cycle; fresh block encodes correctly.
//  - Input gating: in_valid_i=1 during ENCODE -> ignored; back-to-back random blocks match C model.
//  - With TURBO_ENC_PUNCT_EN: par_en_o = 01,10,01,... for k=0..18, then 11,11.

Source files
------------

// File: rtl/turbo_pkg.sv
// Shared definitions for the turbo encoder and its SISO decoder partner.
// Holds the encoder FSM states, trellis sizing and the 4-state trellis
// functions: next state = {u, s[1]}, parity = u ^ s[0].
package turbo_pkg;

  typedef enum logic [1:0] {
    LOAD   = 2'd0,
    ENCODE = 2'd1,
    TAIL   = 2'd2
  } enc_fsm_e;

  localparam int TAIL_LEN = 2;
  localparam int N_STATES = 4;
  localparam int SW       = $clog2(N_STATES);

  // Shift the new input bit into the MSB; the LSB falls off.
  function automatic logic [SW-1:0] trellis_next(input logic [SW-1:0] s, input logic u);
    return {u, s[SW-1]};
  endfunction

  // Feed-forward parity: the input bit against the bit two steps back.
  function automatic logic trellis_par(input logic [SW-1:0] s, input logic u);
    return u ^ s[0];
  endfunction

endpackage

// File: rtl/rsc_enc_core.sv
// Single constituent encoder: one 4-state trellis register plus parity.
// Parity is combinational from the held state and the current input bit,
// so it stays stable for as long as the step is not accepted.
module rsc_enc_core
  import turbo_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          step_en,
  input  logic          u,
  output logic          par,
  output logic [SW-1:0] state
);

  // Encoder memory advances only on an accepted beat; clr returns it to zero.
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      state <= '0;
    end else if (step_en) begin
      state <= trellis_next(state, u);
    end
  end

  assign par = trellis_par(state, u);

endmodule

// File: rtl/turbo_block_encoder.sv
// Rate-1/3 turbo block encoder: buffers K info bits, then emits K data steps
// and TAIL_LEN tail steps of (sys, par1, par2) over a valid/ready handshake.
// Encoder 1 sees natural order, encoder 2 sees pi(k) = (P*k + OFF) mod K,
// with the interleaver address stepped by add-and-wrap instead of a modulo.
// Optional macro TURBO_ENC_PUNCT_EN: alternate par_en_o during data steps
// (rate 1/2); data outputs are unaffected by it.
module turbo_block_encoder
  import turbo_pkg::*;
#(
  parameter int K   = 19,
  parameter int P   = 7,
  parameter int OFF = 0
) (
  input  logic       clk_p_i,
  input  logic       rst_n_i,
  input  logic       in_bit_i,
  input  logic       in_valid_i,
  output logic       in_ready_o,
  output logic       sys_o,
  output logic       par1_o,
  output logic       par2_o,
  output logic [1:0] par_en_o,
  output logic       out_valid_o,
  input  logic       out_ready_i,
  output logic       out_last_o
);

  localparam int W = $clog2(K + TAIL_LEN);
  localparam logic [W-1:0] OFF_W     = W'(OFF);
  localparam logic [W-1:0] LAST_DATA = W'(K - 1);
  localparam logic [W:0]   P_X       = (W+1)'(P);
  localparam logic [W:0]   K_X       = (W+1)'(K);

  enc_fsm_e          fsm;
  logic [W-1:0]      wr_cnt;
  logic [W-1:0]      step;
  logic [W-1:0]      addr;
  logic [(1<<W)-1:0] bit_buf;

  logic              in_fire;
  logic              fire;
  logic              last_fire;
  logic              u1;
  logic              u2;
  logic [W:0]        addr_sum;
  logic [W-1:0]      addr_nxt;
  logic [SW-1:0]     s1;
  logic [SW-1:0]     s2;

  assign in_fire   = in_valid_i & in_ready_o;
  assign fire      = out_valid_o & out_ready_i;
  assign last_fire = fire & out_last_o;

  // Interleaver address: one add, one conditional subtract of K.
  assign addr_sum = {1'b0, addr} + P_X;
  assign addr_nxt = (addr_sum >= K_X) ? W'(addr_sum - K_X) : W'(addr_sum);

  // Tail steps drive u=0 into both encoders, flushing them back to state 0.
  assign u1 = (fsm == ENCODE) ? bit_buf[step] : 1'b0;
  assign u2 = (fsm == ENCODE) ? bit_buf[addr] : 1'b0;

  // Info-bit buffer; deliberately not reset, a new block overwrites it.
  always_ff @(posedge clk_p_i) begin
    if (in_fire) begin
      bit_buf[wr_cnt] <= in_bit_i;
    end
  end

  // Block sequencing: LOAD collects K bits, ENCODE/TAIL emit K+2 beats.
  always_ff @(posedge clk_p_i) begin
    if (!rst_n_i) begin
      fsm         <= LOAD;
      wr_cnt      <= '0;
      step        <= '0;
      addr        <= OFF_W;
      in_ready_o  <= 1'b1;
      out_valid_o <= 1'b0;
      out_last_o  <= 1'b0;
    end else begin
      case (fsm)
        LOAD: begin
          if (in_fire) begin
            if (wr_cnt == LAST_DATA) begin
              fsm         <= ENCODE;
              wr_cnt      <= '0;
              in_ready_o  <= 1'b0;
              out_valid_o <= 1'b1;
            end else begin
              wr_cnt <= wr_cnt + 1'b1;
            end
          end
        end
        ENCODE: begin
          if (fire) begin
            step <= step + 1'b1;
            addr <= addr_nxt;
            if (step == LAST_DATA) begin
              fsm <= TAIL;
            end
          end
        end
        TAIL: begin
          if (fire) begin
            if (!out_last_o) begin
              step       <= step + 1'b1;
              out_last_o <= 1'b1;
            end else begin
              fsm         <= LOAD;
              step        <= '0;
              addr        <= OFF_W;
              in_ready_o  <= 1'b1;
              out_valid_o <= 1'b0;
              out_last_o  <= 1'b0;
            end
          end
        end
        default: begin
          fsm         <= LOAD;
          in_ready_o  <= 1'b1;
          out_valid_o <= 1'b0;
          out_last_o  <= 1'b0;
        end
      endcase
    end
  end

  rsc_enc_core u_enc1 (
    .clk     (clk_p_i),
    .rst_n   (rst_n_i),
    .clr     (last_fire),
    .step_en (fire),
    .u       (u1),
    .par     (par1_o),
    .state   (s1)
  );

  rsc_enc_core u_enc2 (
    .clk     (clk_p_i),
    .rst_n   (rst_n_i),
    .clr     (last_fire),
    .step_en (fire),
    .u       (u2),
    .par     (par2_o),
    .state   (s2)
  );

  // In LOAD both encoders sit at state 0 with u=0, so parity reads 0 there.
  assign sys_o = u1;

`ifdef TURBO_ENC_PUNCT_EN
  assign par_en_o = (fsm == ENCODE) ? (step[0] ? 2'b10 : 2'b01) : 2'b11;
`else
  assign par_en_o = 2'b11;
`endif

endmodule
